// File: rtl/input_module.sv
// Operator input block: debounced enter button pushes a switch word into a
// per-process FIFO that the CPU drains with IN, stalling on an empty queue.
module input_module #(
   parameter int DATA_WIDTH      = 32,
   parameter int NPROCESS        = 11,
   parameter int DEPTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enter,
   input  logic [DATA_WIDTH-1:0] switches,
   input  logic [DATA_WIDTH-1:0] WritepId,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] ReadpId,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  empty,
   output logic                  full,
   output logic                  stall,
   output logic                  overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int IW = (NPROCESS > 1) ? $clog2(NPROCESS) : 1;
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      PUSH,
      RELEASE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          en_m, en_s;

   logic [DATA_WIDTH-1:0] mem [NPROCESS][DEPTH];
   logic [PW-1:0]         wr_ptr [NPROCESS];
   logic [PW-1:0]         rd_ptr [NPROCESS];
   logic [PW:0]           count  [NPROCESS];

   logic          w_ok, r_ok;
   logic [IW-1:0] widx, ridx;
   logic [PW:0]   w_cnt, r_cnt;
   logic          pop, push, accept, drop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         en_m <= 1'b0;
         en_s <= 1'b0;
      end else begin
         en_m <= enter;
         en_s <= en_m;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (en_s) begin
               state_n = PRESS;
               cnt_n   = '0;
            end
         end
         PRESS: begin
            if (!en_s)
               state_n = IDLE;
            else if (cnt == CNT_LAST)
               state_n = PUSH;
            else
               cnt_n = cnt + CW'(1);
         end
         PUSH: begin
            state_n = RELEASE;
            cnt_n   = '0;
         end
         RELEASE: begin
            if (en_s)
               cnt_n = '0;
            else if (cnt == CNT_LAST)
               state_n = IDLE;
            else
               cnt_n = cnt + CW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   // Out-of-range process ids behave as an empty, never-full queue
   always_comb begin
      w_ok    = WritepId < DATA_WIDTH'(NPROCESS);
      r_ok    = ReadpId < DATA_WIDTH'(NPROCESS);
      widx    = WritepId[IW-1:0];
      ridx    = ReadpId[IW-1:0];
      w_cnt   = w_ok ? count[widx] : '0;
      r_cnt   = r_ok ? count[ridx] : '0;
      empty   = (r_cnt == '0);
      full    = w_ok && (w_cnt == CNT_FULL);
      pop     = rd_en && !empty;
      stall   = rd_en && empty;
      dataout = empty ? '0 : mem[ridx][rd_ptr[ridx]];
      push    = (state == PUSH);
      accept  = push && w_ok && (!full || (pop && (ridx == widx)));
      drop    = push && !accept;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int q = 0; q < NPROCESS; q++) begin
            wr_ptr[q] <= '0;
            rd_ptr[q] <= '0;
            count[q]  <= '0;
         end
         overflow <= 1'b0;
      end else begin
         for (int q = 0; q < NPROCESS; q++) begin
            logic inc, dec;
            inc = accept && (widx == IW'(q));
            dec = pop && (ridx == IW'(q));
            if (inc)
               wr_ptr[q] <= wr_ptr[q] + PW'(1);
            if (dec)
               rd_ptr[q] <= rd_ptr[q] + PW'(1);
            if (inc && !dec)
               count[q] <= count[q] + (PW + 1)'(1);
            else if (dec && !inc)
               count[q] <= count[q] - (PW + 1)'(1);
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

   // When full with a same-cycle pop, the write lands in the slot being read;
   // the popped word was already taken combinationally from the old head.
   always_ff @(posedge clock) begin
      if (accept)
         mem[widx][wr_ptr[widx]] <= switches;
   end

endmodule

// File: tb/tb_input_module.sv
// Bench for input_module: directed tables, multi-cycle corner sequences
// and a randomized run against a queue-based reference model.
module tb_input_module;

   localparam int DW  = 32;
   localparam int NP  = 11;
   localparam int DEB = 20;

   logic          clock = 1'b0;
   logic          reset;
   logic          enter;
   logic [DW-1:0] switches;
   logic [DW-1:0] WritepId;
   logic          rd_en;
   logic [DW-1:0] ReadpId;
   logic [DW-1:0] dataout;
   logic          empty;
   logic          full;
   logic          stall;
   logic          overflow;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit          is_push;
      int          pid;
      logic [31:0] data;
      logic [31:0] exp_dout;
      bit          exp_empty;
      bit          exp_full;
      bit          exp_ovf;
   } vec_t;

   vec_t        tv[$];
   logic [31:0] mq[NP][$];
   bit          movf;

   input_module #(
      .DATA_WIDTH(DW),
      .NPROCESS(NP),
      .DEPTH(4),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enter(enter),
      .switches(switches),
      .WritepId(WritepId),
      .rd_en(rd_en),
      .ReadpId(ReadpId),
      .dataout(dataout),
      .empty(empty),
      .full(full),
      .stall(stall),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      rd_en    = 1'b1;
      ReadpId  = 0;
      WritepId = 0;
      #1;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_dout", dataout, 0);
      chk("rst_stall", 32'(stall), 1);
      chk("rst_ovf", 32'(overflow), 0);
      rd_en = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
   endtask

   task automatic press(input int pid, input logic [31:0] d);
      WritepId = pid;
      switches = d;
      enter    = 1'b1;
      step(DEB + 10);
      enter = 1'b0;
      step(DEB + 10);
   endtask

   task automatic pop_chk(input string name, input int pid,
                          input logic [31:0] exp);
      ReadpId = pid;
      rd_en   = 1'b1;
      #1;
      chk({name, "_dout"}, dataout, exp);
      chk({name, "_stall"}, 32'(stall), 0);
      step(1);
      rd_en = 1'b0;
   endtask

   function automatic vec_t mk_push(int pid, logic [31:0] d, bit f, bit o);
      vec_t v;
      v = '{1'b1, pid, d, 32'h0, 1'b0, f, o};
      return v;
   endfunction

   function automatic vec_t mk_pop(int pid, logic [31:0] d, bit e, bit o);
      vec_t v;
      v = '{1'b0, pid, 32'h0, d, e, 1'b0, o};
      return v;
   endfunction

   initial begin
      reset    = 1'b1;
      enter    = 1'b0;
      switches = '0;
      WritepId = '0;
      ReadpId  = '0;
      rd_en    = 1'b0;

      for (int i = 1; i <= 5; i++)
         tv.push_back(mk_push(0, i, i >= 4, i == 5));
      for (int i = 1; i <= 4; i++)
         tv.push_back(mk_pop(0, i, i == 4, 1'b1));
      tv.push_back(mk_push(1, 32'h11, 1'b0, 1'b1));
      tv.push_back(mk_push(7, 32'h71, 1'b0, 1'b1));
      tv.push_back(mk_push(1, 32'h12, 1'b0, 1'b1));
      tv.push_back(mk_push(7, 32'h72, 1'b0, 1'b1));
      tv.push_back(mk_pop(7, 32'h71, 1'b0, 1'b1));
      tv.push_back(mk_pop(1, 32'h11, 1'b0, 1'b1));
      tv.push_back(mk_pop(1, 32'h12, 1'b1, 1'b1));
      tv.push_back(mk_pop(7, 32'h72, 1'b1, 1'b1));

      @(posedge clock);
      #1;
      do_reset();

      // glitch, then long hold: exactly one push
      WritepId = 2;
      ReadpId  = 2;
      switches = 32'hA5;
      enter    = 1'b1;
      step(3);
      enter = 1'b0;
      step(DEB + 10);
      chk("glitch_empty", 32'(empty), 1);
      enter = 1'b1;
      step(5 * DEB);
      enter = 1'b0;
      step(DEB + 10);
      chk("t1_empty", 32'(empty), 0);
      chk("t1_dout", dataout, 32'hA5);
      pop_chk("t2_pop", 2, 32'hA5);
      chk("t2_empty", 32'(empty), 1);
      chk("t2_dout0", dataout, 0);
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_stall", 32'(stall), 1);
         step(1);
      end
      rd_en = 1'b0;
      press(2, 32'h5A);
      pop_chk("t2_after", 2, 32'h5A);
      chk("t2_empty2", 32'(empty), 1);

      do_reset();
      foreach (tv[i]) begin
         if (tv[i].is_push) begin
            press(tv[i].pid, tv[i].data);
            #1;
            chk($sformatf("tv%0d_full", i), 32'(full), 32'(tv[i].exp_full));
         end else begin
            pop_chk($sformatf("tv%0d", i), tv[i].pid, tv[i].exp_dout);
            #1;
            chk($sformatf("tv%0d_empty", i), 32'(empty),
                32'(tv[i].exp_empty));
         end
         chk($sformatf("tv%0d_ovf", i), 32'(overflow), 32'(tv[i].exp_ovf));
      end

      // full queue, push coincides with pop on the same queue
      do_reset();
      for (int i = 1; i <= 4; i++)
         press(3, 32'h30 + i);
      WritepId = 3;
      #1;
      chk("t4_full", 32'(full), 1);
      @(posedge clock);
      #1;
      switches = 32'h35;
      enter    = 1'b1;
      step(DEB + 3);
      ReadpId = 3;
      rd_en   = 1'b1;
      #1;
      chk("t4_coinc_dout", dataout, 32'h31);
      step(1);
      rd_en = 1'b0;
      step(10);
      enter = 1'b0;
      step(DEB + 10);
      chk("t4_ovf", 32'(overflow), 0);
      chk("t4_full2", 32'(full), 1);
      for (int i = 2; i <= 5; i++)
         pop_chk("t4_pop", 3, 32'h30 + i);
      chk("t4_empty", 32'(empty), 1);

      // reset during PRESS
      do_reset();
      WritepId = 6;
      ReadpId  = 6;
      enter    = 1'b1;
      step(DEB / 2 + 3);
      do_reset();
      enter = 1'b0;
      step(2 * DEB + 10);
      chk("t5p_empty", 32'(empty), 1);
      chk("t5p_ovf", 32'(overflow), 0);

      // reset during RELEASE
      WritepId = 6;
      ReadpId  = 6;
      switches = 32'h66;
      enter    = 1'b1;
      step(DEB + 10);
      chk("t5r_pushed", 32'(empty), 0);
      enter = 1'b0;
      step(3);
      do_reset();
      WritepId = 6;
      ReadpId  = 6;
      step(2 * DEB + 10);
      chk("t5r_empty", 32'(empty), 1);
      chk("t5r_ovf", 32'(overflow), 0);

      // button held through reset
      switches = 32'h67;
      enter    = 1'b1;
      step(DEB / 2);
      do_reset();
      WritepId = 6;
      ReadpId  = 6;
      step(DEB / 2);
      chk("t5h_early", 32'(empty), 1);
      step(DEB + 10);
      chk("t5h_pushed", 32'(empty), 0);
      enter = 1'b0;
      step(DEB + 10);
      pop_chk("t5h_pop", 6, 32'h67);
      chk("t5h_once", 32'(empty), 1);

      // invalid process id
      do_reset();
      press(11, 32'hBAD);
      chk("t6_ovf", 32'(overflow), 1);
      ReadpId = 11;
      rd_en   = 1'b1;
      #1;
      chk("t6_empty", 32'(empty), 1);
      chk("t6_dout", dataout, 0);
      chk("t6_stall", 32'(stall), 1);
      step(1);
      rd_en = 1'b0;
      #1;
      chk("t6_stall0", 32'(stall), 0);

      // pointer wrap
      do_reset();
      for (int i = 0; i < 10; i++) begin
         press(5, 32'h500 + i);
         pop_chk($sformatf("wrap%0d", i), 5, 32'h500 + i);
      end
      chk("wrap_empty", 32'(empty), 1);

      // randomized against reference queues
      do_reset();
      movf = 1'b0;
      for (int i = 0; i < 60; i++) begin
         int          pid;
         logic [31:0] d;
         bit          e;
         pid = ($urandom_range(0, 7) == 0) ? 11 : $urandom_range(0, 2);
         if ($urandom_range(0, 2) != 0) begin
            d = $urandom;
            press(pid, d);
            if (pid >= NP || mq[pid].size() == 4)
               movf = 1'b1;
            else
               mq[pid].push_back(d);
            WritepId = pid;
            #1;
            chk("rnd_ovf", 32'(overflow), 32'(movf));
            chk("rnd_full", 32'(full),
                32'(pid < NP && mq[pid].size() == 4));
         end else begin
            e       = (pid >= NP) || (mq[pid].size() == 0);
            ReadpId = pid;
            rd_en   = 1'b1;
            #1;
            chk("rnd_empty", 32'(empty), 32'(e));
            chk("rnd_stall", 32'(stall), 32'(e));
            chk("rnd_dout", dataout, e ? 32'h0 : mq[pid][0]);
            step(1);
            rd_en = 1'b0;
            if (!e)
               void'(mq[pid].pop_front());
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
